// File: rtl/prog_loader.sv
// Byte-stream program loader: decodes framed commands, packs little-endian
// 32-bit words and writes them to instruction or data RAM; gates CPU pc_stall.
module prog_loader #(
  parameter int unsigned ADDR_W   = 12,
  parameter logic [7:0]  CMD_IMEM = 8'hA5,
  parameter logic [7:0]  CMD_DMEM = 8'h5A,
  parameter logic [7:0]  CMD_RUN  = 8'h0F,
  parameter logic [7:0]  CMD_HALT = 8'hF0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        s_dat,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] w_addr,
  output logic [31:0]       w_dat,
  output logic [3:0]        w_byte_enb,
  output logic              i_w_enb,
  output logic              d_w_enb,
  output logic              pc_stall,
  output logic              busy,
  output logic              err,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    DATA,
    RUN
  } state_t;

  state_t              state_q, state_d;
  logic                s_ready_q, s_ready_d;
  logic                tgt_dmem_q, tgt_dmem_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [23:0]         word_q, word_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic [31:0]         w_dat_q, w_dat_d;
  logic                i_w_enb_q, i_w_enb_d;
  logic                d_w_enb_q, d_w_enb_d;
  logic                err_q, err_d;
  logic [15:0]         words_loaded_q, words_loaded_d;
  logic                xfer;

  assign xfer = s_valid && s_ready_q;

  always_comb begin
    state_d        = state_q;
    s_ready_d      = 1'b1;
    tgt_dmem_d     = tgt_dmem_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    byte_idx_d     = byte_idx_q;
    word_d         = word_q;
    w_addr_d       = w_addr_q;
    w_dat_d        = w_dat_q;
    i_w_enb_d      = 1'b0;
    d_w_enb_d      = 1'b0;
    err_d          = err_q;
    words_loaded_d = words_loaded_q;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (s_dat == CMD_IMEM || s_dat == CMD_DMEM) begin
            tgt_dmem_d     = (s_dat == CMD_DMEM);
            words_loaded_d = '0;
            state_d        = CNT_LO;
          end else if (s_dat == CMD_RUN) begin
            state_d = RUN;
          end else if (s_dat != CMD_HALT) begin
            err_d = 1'b1;
          end
        end
      end
      CNT_LO: begin
        if (xfer) begin
          cnt_d[7:0] = s_dat;
          state_d    = CNT_HI;
        end
      end
      CNT_HI: begin
        if (xfer) begin
          cnt_d[15:8] = s_dat;
          addr_d      = '0;
          byte_idx_d  = '0;
          state_d     = ({s_dat, cnt_q[7:0]} == 16'd0) ? IDLE : DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          if (byte_idx_q == 2'd3) begin
            w_dat_d        = {s_dat, word_q};
            w_addr_d       = addr_q;
            i_w_enb_d      = !tgt_dmem_q;
            d_w_enb_d      = tgt_dmem_q;
            addr_d         = addr_q + ADDR_W'(1);
            words_loaded_d = words_loaded_q + 16'd1;
            byte_idx_d     = '0;
            // words_loaded counts from zero per frame, so it doubles as the word counter
            if (words_loaded_q + 16'd1 == cnt_q) begin
              state_d = IDLE;
            end
          end else begin
            case (byte_idx_q)
              2'd0:    word_d[7:0]   = s_dat;
              2'd1:    word_d[15:8]  = s_dat;
              default: word_d[23:16] = s_dat;
            endcase
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      RUN: begin
        if (xfer && s_dat == CMD_HALT) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      s_ready_q      <= 1'b0;
      tgt_dmem_q     <= 1'b0;
      cnt_q          <= '0;
      addr_q         <= '0;
      byte_idx_q     <= '0;
      word_q         <= '0;
      w_addr_q       <= '0;
      w_dat_q        <= '0;
      i_w_enb_q      <= 1'b0;
      d_w_enb_q      <= 1'b0;
      err_q          <= 1'b0;
      words_loaded_q <= '0;
    end else begin
      state_q        <= state_d;
      s_ready_q      <= s_ready_d;
      tgt_dmem_q     <= tgt_dmem_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      byte_idx_q     <= byte_idx_d;
      word_q         <= word_d;
      w_addr_q       <= w_addr_d;
      w_dat_q        <= w_dat_d;
      i_w_enb_q      <= i_w_enb_d;
      d_w_enb_q      <= d_w_enb_d;
      err_q          <= err_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign w_addr       = w_addr_q;
  assign w_dat        = w_dat_q;
  assign i_w_enb      = i_w_enb_q;
  assign d_w_enb      = d_w_enb_q;
  assign w_byte_enb   = (i_w_enb_q || d_w_enb_q) ? 4'hF : 4'h0;
  assign pc_stall     = (state_q != RUN);
  assign busy         = (state_q == CNT_LO) || (state_q == CNT_HI) || (state_q == DATA);
  assign err          = err_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (default and 2-bit address) share one
// byte stream; expected RAM writes come from the frames the bench builds.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_dat;
  logic        s_valid;

  logic        a_s_ready, a_i_w_enb, a_d_w_enb, a_pc_stall, a_busy, a_err;
  logic [11:0] a_w_addr;
  logic [31:0] a_w_dat;
  logic [3:0]  a_w_byte_enb;
  logic [15:0] a_words_loaded;

  logic        b_s_ready, b_i_w_enb, b_d_w_enb, b_pc_stall, b_busy, b_err;
  logic [1:0]  b_w_addr;
  logic [31:0] b_w_dat;
  logic [3:0]  b_w_byte_enb;
  logic [15:0] b_words_loaded;

  always #5 clk = ~clk;

  prog_loader dut_a (
    .clk(clk), .rst(rst), .s_dat(s_dat), .s_valid(s_valid), .s_ready(a_s_ready),
    .w_addr(a_w_addr), .w_dat(a_w_dat), .w_byte_enb(a_w_byte_enb),
    .i_w_enb(a_i_w_enb), .d_w_enb(a_d_w_enb), .pc_stall(a_pc_stall),
    .busy(a_busy), .err(a_err), .words_loaded(a_words_loaded)
  );

  prog_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .s_dat(s_dat), .s_valid(s_valid), .s_ready(b_s_ready),
    .w_addr(b_w_addr), .w_dat(b_w_dat), .w_byte_enb(b_w_byte_enb),
    .i_w_enb(b_i_w_enb), .d_w_enb(b_d_w_enb), .pc_stall(b_pc_stall),
    .busy(b_busy), .err(b_err), .words_loaded(b_words_loaded)
  );

  typedef struct packed {
    logic        dmem;
    logic [11:0] addr;
    logic [31:0] dat;
  } wr_t;

  int unsigned tests = 0;
  int unsigned fails = 0;
  wr_t exp_a[$], exp_b[$], obs_a[$], obs_b[$];
  logic [31:0] wq[$];
  logic exp_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (a_i_w_enb || a_d_w_enb) obs_a.push_back(wr_t'({a_d_w_enb, a_w_addr, a_w_dat}));
    if (b_i_w_enb || b_d_w_enb) obs_b.push_back(wr_t'({b_d_w_enb, 10'd0, b_w_addr, b_w_dat}));
    check("a_both_enables", {63'd0, a_i_w_enb && a_d_w_enb}, 64'd0);
    check("a_byte_enb", {60'd0, a_w_byte_enb}, (a_i_w_enb || a_d_w_enb) ? 64'hF : 64'h0);
    check("b_byte_enb", {60'd0, b_w_byte_enb}, (b_i_w_enb || b_d_w_enb) ? 64'hF : 64'h0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] junk_idle();
    logic [7:0] v;
    do v = 8'($urandom); while (v == 8'hA5 || v == 8'h5A || v == 8'h0F || v == 8'hF0);
    return v;
  endfunction

  function automatic logic [7:0] junk_run();
    logic [7:0] v;
    do v = 8'($urandom); while (v == 8'hF0);
    return v;
  endfunction

  task automatic send(input logic [7:0] b, input int unsigned gap);
    int unsigned n = 0;
    while (!(a_s_ready && b_s_ready) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!(a_s_ready && b_s_ready)) check("s_ready_timeout", 64'd0, 64'd1);
    s_dat = b; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; s_dat = 8'($urandom);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic compare_writes();
    check("a_write_count", 64'(obs_a.size()), 64'(exp_a.size()));
    check("b_write_count", 64'(obs_b.size()), 64'(exp_b.size()));
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) check("a_write", 64'(obs_a[i]), 64'(exp_a[i]));
    for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++) check("b_write", 64'(obs_b[i]), 64'(exp_b[i]));
    obs_a.delete(); obs_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  // Sends one load frame for the words in wq; gap_max > 0 randomizes bubbles
  task automatic load(input logic dmem, input int unsigned gap_max, input bit alternate);
    int unsigned cnt = wq.size();
    int unsigned g;
    g = alternate ? 1 : $urandom_range(0, gap_max);
    send(dmem ? 8'h5A : 8'hA5, g);
    check("busy_after_cmd", {63'd0, a_busy}, 64'd1);
    check("wl_cleared", 64'(a_words_loaded), 64'd0);
    send(8'(cnt), alternate ? 1 : $urandom_range(0, gap_max));
    send(8'(cnt >> 8), alternate ? 1 : $urandom_range(0, gap_max));
    for (int k = 0; k < cnt; k++) begin
      logic [11:0] ka = 12'(k);
      logic [31:0] w = wq[k];
      exp_a.push_back(wr_t'({dmem, ka, w}));
      exp_b.push_back(wr_t'({dmem, 10'd0, ka[1:0], w}));
      for (int j = 0; j < 4; j++) begin
        send(w[8*j +: 8], alternate ? 1 : $urandom_range(0, gap_max));
        if (j == 3 && k == cnt - 1) check("idle_with_last_pulse", {63'd0, a_busy}, 64'd0);
      end
    end
    repeat (2) begin @(posedge clk); #1; end
    compare_writes();
    check("a_words_loaded", 64'(a_words_loaded), 64'(cnt));
    check("b_words_loaded", 64'(b_words_loaded), 64'(cnt));
    check("busy_after_frame", {63'd0, a_busy}, 64'd0);
    check("stall_after_frame", {62'd0, a_pc_stall, b_pc_stall}, 64'd3);
    check("err_after_frame", {62'd0, a_err, b_err}, {62'd0, exp_err, exp_err});
    wq.delete();
  endtask

  task automatic check_reset_vals();
    check("rst_a_ctl", {56'd0, a_s_ready, a_pc_stall, a_i_w_enb, a_d_w_enb, a_busy, a_err, 2'd0},
          {56'd0, 8'b0100_0000});
    check("rst_a_wbus", {a_w_byte_enb, a_w_addr, a_w_dat}, 64'd0);
    check("rst_a_wl", 64'(a_words_loaded), 64'd0);
    check("rst_b_ctl", {56'd0, b_s_ready, b_pc_stall, b_i_w_enb, b_d_w_enb, b_busy, b_err, 2'd0},
          {56'd0, 8'b0100_0000});
    check("rst_b_wbus", {b_w_byte_enb, b_w_addr, b_w_dat, b_words_loaded}, 64'd0);
  endtask

  task automatic release_reset();
    rst = 1'b1;
    check("s_ready_before_edge", {63'd0, a_s_ready}, 64'd0);
    @(posedge clk); #1;
    check("s_ready_after_edge", {62'd0, a_s_ready, b_s_ready}, 64'd3);
  endtask

  task automatic run_session(input int unsigned n_junk);
    send(8'h0F, 0);
    check("stall_low_after_run", {62'd0, a_pc_stall, b_pc_stall}, 64'd0);
    for (int i = 0; i < n_junk; i++) send(junk_run(), $urandom_range(0, 1));
    check("stall_low_in_run", {63'd0, a_pc_stall}, 64'd0);
    check("s_ready_in_run", {63'd0, a_s_ready}, 64'd1);
    check("err_in_run", {62'd0, a_err, b_err}, {62'd0, exp_err, exp_err});
    send(8'hF0, 0);
    check("stall_high_after_halt", {62'd0, a_pc_stall, b_pc_stall}, 64'd3);
    repeat (2) begin @(posedge clk); #1; end
    compare_writes();
  endtask

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_dat = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    release_reset();

    // IMEM load of two instructions
    wq = '{32'h0050_0013, 32'h00A0_0093};
    load(1'b0, 0, 1'b0);

    // DMEM load then RUN with assorted bytes that must be discarded
    wq = '{32'hDEAD_BEEF};
    load(1'b1, 0, 1'b0);
    run_session(8);

    // HALT while idle is ignored
    send(8'hF0, 0);
    check("halt_in_idle", {61'd0, a_pc_stall, a_busy, a_err}, 64'b100);

    // zero count, then unknown command, then err stays sticky
    load(1'b0, 0, 1'b0);
    send(8'h33, 0);
    exp_err = 1'b1;
    check("err_set", {62'd0, a_err, b_err}, 64'd3);
    wq = '{32'($urandom)};
    load(1'b0, 0, 1'b0);
    run_session(3);

    // valid toggling every cycle through a data frame
    wq = '{32'($urandom)};
    load(1'b1, 0, 1'b1);

    // count 5: 2-bit instance wraps to address 0
    wq = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    load(1'b0, 0, 1'b0);

    // reset after two data bytes
    send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0); send(8'h11, 0); send(8'h22, 0);
    rst = 1'b0;
    #1;
    exp_err = 1'b0;
    check_reset_vals();
    @(posedge clk); #1;
    compare_writes();
    release_reset();
    wq = '{32'hCAFE_F00D};
    load(1'b0, 0, 1'b0);

    // reset while a write pulse is high kills the pulse at once
    send(8'h5A, 0); send(8'h01, 0); send(8'h00, 0);
    send(8'h44, 0); send(8'h33, 0); send(8'h22, 0); send(8'h11, 0);
    check("pulse_before_reset", {62'd0, a_d_w_enb, b_d_w_enb}, 64'd3);
    rst = 1'b0;
    #1;
    check_reset_vals();
    @(posedge clk); #1;
    compare_writes();
    release_reset();

    // randomized mix of frames, run sessions and bad commands
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          int unsigned n = $urandom_range(1, 7);
          for (int k = 0; k < n; k++) wq.push_back($urandom);
          load(1'($urandom), 2, 1'b0);
        end
        2: run_session($urandom_range(0, 5));
        default: begin
          send(junk_idle(), $urandom_range(0, 1));
          exp_err = 1'b1;
          check("err_random", {62'd0, a_err, b_err}, 64'd3);
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

- Byte-stream program loader sitting upstream of the CPU and its two bram32 memories (instruction and data).
- Receives a framed byte stream (e.g. from a UART receiver), assembles little-endian 32-bit words and writes them into instruction or data RAM.
- Holds the CPU's `pc_stall` asserted until a RUN command arrives.
- Replaces the `$readmemh` preload used in simulation with a synthesizable path.

## Interface
Parameters:
- `ADDR_W`, 12: width of the RAM word address (`RAM_ADDR_WIDTH`).
- `CMD_IMEM`, 8'hA5: load instruction RAM.
- `CMD_DMEM`, 8'h5A: load data RAM.
- `CMD_RUN`, 8'h0F: release `pc_stall`.
- `CMD_HALT`, 8'hF0: reassert `pc_stall`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`, in, 1: system clock, rising edge.
  - `rst`, in, 1: asynchronous, active-low reset.
- Byte stream input:
  - `s_dat`, in, 8: stream byte.
  - `s_valid`, in, 1: `s_dat` valid.
  - `s_ready`, out, 1: loader accepts the byte. A transfer occurs when `s_valid` and `s_ready` are both high on a rising edge.
- Shared RAM write bus:
  - `w_addr`, out, ADDR_W: write word address.
  - `w_dat`, out, 32: write data.
  - `w_byte_enb`, out, 4: always 4'hF when either enable is high, else 4'h0.
- RAM write enables:
  - `i_w_enb`, out, 1: instruction RAM write enable, one-cycle pulse.
  - `d_w_enb`, out, 1: data RAM write enable, one-cycle pulse.
- CPU control and status:
  - `pc_stall`, out, 1: CPU stall; high while not running.
  - `busy`, out, 1: high in states CNT_LO, CNT_HI and DATA.
  - `err`, out, 1: sticky; set on an unknown command byte.
  - `words_loaded`, out, 16: words written by the most recent load command.

## Operation
- **States:** IDLE, CNT_LO, CNT_HI, DATA, RUN.
- **IDLE:** accepts one command byte.
  - CMD_IMEM or CMD_DMEM: latch the target RAM, clear `words_loaded`, go to CNT_LO.
  - CMD_RUN: go to RUN.
  - CMD_HALT: ignored; stay in IDLE.
  - Any other byte: set `err`, stay in IDLE.
- **CNT_LO / CNT_HI:** accept the word count, low byte then high byte (16 bits).
  - Count == 0: return from CNT_HI to IDLE with no writes.
  - Otherwise: go to DATA with the address counter = 0.
- **DATA:** bytes are assembled little-endian (first byte → bits [7:0]).
  - On the 4th byte of a word: register `w_dat` = assembled word and `w_addr` = address counter; pulse the selected enable for one cycle; increment the address counter and `words_loaded`.
  - After the last word's 4th byte: go to IDLE.
  - The address counter wraps modulo 2^ADDR_W. Counts beyond RAM size overwrite from address 0; this is not an error.
- **RUN:** `pc_stall` = 0; `s_ready` stays 1.
  - CMD_HALT: `pc_stall` = 1, go to IDLE.
  - All other bytes are consumed and discarded; `err` is not set.
- `err` is cleared only by reset.
- Non-target enable stays 0. The loader never drives `i_w_enb` and `d_w_enb` high together.

## Timing
- **Reset values (while `rst` = 0):**
  - state IDLE, `pc_stall` = 1, `s_ready` = 0.
  - `i_w_enb` = `d_w_enb` = 0, `w_byte_enb` = 0.
  - `w_addr` = 0, `w_dat` = 0.
  - `busy` = 0, `err` = 0, `words_loaded` = 0.
- `s_ready` is registered. It rises on the first rising edge after `rst` deasserts and stays 1 in every state thereafter. The loader never back-pressures; one byte per cycle is sustained.
- **Write latency:**
  - The 4th byte is accepted at edge N.
  - `w_addr`, `w_dat` and enable are valid after edge N and are sampled by RAM at edge N+1.
  - The enable is low again after edge N+1 unless another word completes exactly at edge N+1. That cannot happen, since a word is at minimum 4 cycles.
- **Transitions:**
  - Last word: state = IDLE after edge N, concurrently with the final write pulse. A command byte at edge N+1 is accepted normally.
  - `pc_stall` falls after the edge that accepts CMD_RUN in IDLE.
  - `pc_stall` rises after the edge that accepts CMD_HALT in RUN.
- **Bubbles:** `s_valid` low cycles inside a frame are allowed. State and partial word are held indefinitely; there is no timeout.
- **Reset mid-load:** async `rst` low mid-frame aborts immediately. All outputs return to their reset values within the same cycle, including any enable pulse in flight. The partial word is discarded; RAM contents already written are untouched.

## Test plan
- **IMEM load:** A5, 02, 00, 13 00 50 00, 93 00 A0 00.
  - `i_w_enb` pulses twice: addr 0 data 0x00500013, then addr 1 data 0x00A00093.
  - `d_w_enb` stays 0; `words_loaded` = 2; state returns to IDLE.
  - `pc_stall` stays 1 throughout.
- **DMEM load + RUN:** 5A, 01, 00, EF BE AD DE, 0F.
  - `d_w_enb` pulse at addr 0 with 0xDEADBEEF.
  - `pc_stall` = 0 one cycle after 0F is accepted.
  - Then F0 → `pc_stall` = 1.
- **Zero count and errors:**
  - A5, 00, 00 → no write pulse, IDLE.
  - Then 33 → `err` = 1 and remains 1 after a valid A5 frame.
  - Bytes 33 sent while in RUN leave `err` unchanged.
- **Bubbles:** DMEM frame of 1 word with `s_valid` toggled 1/0 every cycle.
  - Same write result as back-to-back (addr 0, correct data).
  - Exactly one enable pulse.
- **Address wrap:** with ADDR_W = 2, A5 with count 5 and words 1..5.
  - Writes go to addr 0,1,2,3,0; the last pulse carries value 5.
  - `words_loaded` = 5.
- **Reset mid-frame:** `rst` low after 2 data bytes of an IMEM frame.
  - All outputs at reset values immediately; no enable pulse.
  - After release, a fresh full frame writes addr 0 correctly.
